// File: rtl/cart_bus_sequencer_m.sv
// Game Boy cartridge bus sequencer: request/response front end to timed /RD, /WR, /CS cycles,
// power-up cartridge reset and PHI clock. Define CART_RD_CACHE_EN for a single-entry read cache.
module cart_bus_sequencer_m #(
   parameter int unsigned SETUP_CYC    = 1,
   parameter int unsigned STROBE_CYC   = 2,
   parameter int unsigned RECOVER_CYC  = 1,
   parameter int unsigned RST_HOLD_CYC = 16
) (
   input  logic        clk_4mhz,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        cart_clk,
   output logic        cart_n_rst,
   output logic        cart_n_cs,
   output logic        cart_n_rd,
   output logic        cart_n_wr,
   output logic [15:0] cart_addr,
   output logic [7:0]  cart_dout,
   output logic        cart_doe,
   input  logic [7:0]  cart_din
);

   typedef enum logic [2:0] {
      ST_RST_HOLD,
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_RECOVER
   } state_t;

   localparam logic [7:0] SETUP_LD   = 8'(SETUP_CYC - 1);
   localparam logic [7:0] STROBE_LD  = 8'(STROBE_CYC - 1);
   localparam logic [7:0] RECOVER_LD = 8'(RECOVER_CYC - 1);
   localparam logic [7:0] RST_LD     = 8'(RST_HOLD_CYC - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  div_q, div_d;
   logic        we_q, we_d;
   logic        req_ready_q, req_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [7:0]  rsp_rdata_q, rsp_rdata_d;
   logic        n_rst_q, n_rst_d;
   logic        n_cs_q, n_cs_d;
   logic        n_rd_q, n_rd_d;
   logic        n_wr_q, n_wr_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  dout_q, dout_d;
   logic        doe_q, doe_d;

   logic        addr_ok;
   logic        addr_eram;

`ifdef CART_RD_CACHE_EN
   logic        cache_valid_q, cache_valid_d;
   logic [15:0] cache_addr_q, cache_addr_d;
   logic [7:0]  cache_data_q, cache_data_d;
`endif

   // ROM window 0x0000-0x7FFF and external RAM 0xA000-0xBFFF are the only mapped regions
   assign addr_eram = (req_addr[15:13] == 3'b101);
   assign addr_ok   = ~req_addr[15] | addr_eram;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      div_d       = div_q + 2'd1;
      we_d        = we_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      n_rst_d     = n_rst_q;
      n_cs_d      = n_cs_q;
      n_rd_d      = n_rd_q;
      n_wr_d      = n_wr_q;
      addr_d      = addr_q;
      dout_d      = dout_q;
      doe_d       = doe_q;
`ifdef CART_RD_CACHE_EN
      cache_valid_d = cache_valid_q;
      cache_addr_d  = cache_addr_q;
      cache_data_d  = cache_data_q;
`endif

      case (state_q)
         ST_RST_HOLD: begin
            if (cnt_q == 8'd0) begin
               state_d     = ST_IDLE;
               n_rst_d     = 1'b1;
               req_ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_IDLE: begin
            if (req_valid && req_ready_q) begin
               req_ready_d = 1'b0;
               we_d        = req_we;
`ifdef CART_RD_CACHE_EN
               if (req_we) cache_valid_d = 1'b0;
`endif
               // Decode errors and cache hits skip the bus and answer from RECOVER directly
               if (!addr_ok) begin
                  state_d     = ST_RECOVER;
                  cnt_d       = RECOVER_LD;
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = 8'hFF;
               end
`ifdef CART_RD_CACHE_EN
               else if (!req_we && cache_valid_q && (cache_addr_q == req_addr)) begin
                  state_d     = ST_RECOVER;
                  cnt_d       = RECOVER_LD;
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = cache_data_q;
               end
`endif
               else begin
                  state_d = ST_SETUP;
                  cnt_d   = SETUP_LD;
                  addr_d  = req_addr;
                  n_cs_d  = ~addr_eram;
                  doe_d   = req_we;
                  if (req_we) dout_d = req_wdata;
               end
            end
         end
         ST_SETUP: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_STROBE;
               cnt_d   = STROBE_LD;
               if (we_q) n_wr_d = 1'b0;
               else      n_rd_d = 1'b0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_STROBE: begin
            if (cnt_q == 8'd0) begin
               state_d     = ST_RECOVER;
               cnt_d       = RECOVER_LD;
               n_rd_d      = 1'b1;
               n_wr_d      = 1'b1;
               n_cs_d      = 1'b1;
               rsp_valid_d = 1'b1;
               if (!we_q) begin
                  rsp_rdata_d = cart_din;
`ifdef CART_RD_CACHE_EN
                  cache_valid_d = 1'b1;
                  cache_addr_d  = addr_q;
                  cache_data_d  = cart_din;
`endif
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_RECOVER: begin
            if (cnt_q == 8'd0) begin
               state_d     = ST_IDLE;
               doe_d       = 1'b0;
               req_ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = ST_RST_HOLD;
            cnt_d   = RST_LD;
         end
      endcase

      if (rst) begin
         state_d     = ST_RST_HOLD;
         cnt_d       = RST_LD;
         div_d       = '0;
         we_d        = 1'b0;
         req_ready_d = 1'b0;
         rsp_valid_d = 1'b0;
         rsp_rdata_d = '0;
         n_rst_d     = 1'b0;
         n_cs_d      = 1'b1;
         n_rd_d      = 1'b1;
         n_wr_d      = 1'b1;
         addr_d      = '0;
         dout_d      = '0;
         doe_d       = 1'b0;
`ifdef CART_RD_CACHE_EN
         cache_valid_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk_4mhz) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      we_q        <= we_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      n_rst_q     <= n_rst_d;
      n_cs_q      <= n_cs_d;
      n_rd_q      <= n_rd_d;
      n_wr_q      <= n_wr_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      doe_q       <= doe_d;
`ifdef CART_RD_CACHE_EN
      cache_valid_q <= cache_valid_d;
      cache_addr_q  <= cache_addr_d;
      cache_data_q  <= cache_data_d;
`endif
   end

   assign req_ready  = req_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign cart_clk   = div_q[1];
   assign cart_n_rst = n_rst_q;
   assign cart_n_cs  = n_cs_q;
   assign cart_n_rd  = n_rd_q;
   assign cart_n_wr  = n_wr_q;
   assign cart_addr  = addr_q;
   assign cart_dout  = dout_q;
   assign cart_doe   = doe_q;

endmodule
